// File: rtl/arb_grant_handshake_pkg.sv
// rtl/arb_grant_handshake_pkg.sv - shared readout types and sizing helpers
package arb_grant_handshake_pkg;

    localparam int NUM_PORTS_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    // Address width never collapses to zero, even for one or two ports.
    function automatic int addr_w_f(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_grant_handshake_onehot_to_bin.sv
// rtl/arb_grant_handshake_onehot_to_bin.sv - lowest-set-bit encoder with multi-hot flag
module onehot_to_bin
    import arb_grant_handshake_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = addr_w_f(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] vec_i,
    output logic [ADDR_W-1:0]    bin_o,
    output logic                 multi_hot_o
);

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        bin_o = '0;
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                bin_o = ADDR_W'(i);
            end
        end
    end

    assign multi_hot_o = |(vec_i & (vec_i - NUM_PORTS'(1)));

endmodule

// File: rtl/arb_grant_handshake.sv
// rtl/arb_grant_handshake.sv - gates arbiter requests, encodes grant, FIFO handshake and port acknowledge
module arb_grant_handshake
    import arb_grant_handshake_pkg::*;
#(
    parameter int NUM_PORTS = NUM_PORTS_DEF,
    parameter int ADDR_W    = addr_w_f(NUM_PORTS),
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] req_arb_o,
    input  logic [NUM_PORTS-1:0] gnt_i,
    output logic [ADDR_W-1:0]    addr_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [NUM_PORTS-1:0] ack_o,
    output logic                 busy_o,
    output logic [CNT_W-1:0]     evt_cnt_o,
    output logic                 err_o
);

    state_e                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;

    logic [ADDR_W-1:0]      enc_bin;
    logic                   enc_multi;
    logic [NUM_PORTS-1:0]   gnt_low;

    onehot_to_bin #(
        .NUM_PORTS (NUM_PORTS),
        .ADDR_W    (ADDR_W)
    ) u_enc (
        .vec_i       (gnt_i),
        .bin_o       (enc_bin),
        .multi_hot_o (enc_multi)
    );

    // Keep only the served bit so ack_o stays one-hot under a malformed grant.
    assign gnt_low = gnt_i & (~gnt_i + NUM_PORTS'(1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        req_arb_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                req_arb_o = req_i;
                if (|gnt_i) begin
                    addr_d  = enc_bin;
                    gnt_d   = gnt_low;
                    err_d   = err_q | enc_multi;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (ready_i) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (~|(req_i & gnt_q)) begin
                    gnt_d   = '0;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign addr_o    = addr_q;
    assign valid_o   = (state_q == ST_SEND);
    assign ack_o     = (state_q == ST_ACK) ? gnt_q : '0;
    assign busy_o    = (state_q != ST_IDLE);
    assign evt_cnt_o = cnt_q;
    assign err_o     = err_q;

endmodule

// File: tb/tb_arb_grant_handshake.sv
// tb/tb_arb_grant_handshake.sv - scoreboard bench with port, arbiter and FIFO models
module tb_arb_grant_handshake;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req, req_arb, gnt, ack;
    logic [1:0] addr;
    logic       valid, ready, busy, err;
    logic [3:0] evt_cnt;

    int  vectors = 0;
    int  miscompares = 0;
    int  exp_q[$];
    bit  malformed, early_mode, err_exp;
    int  ready_mode, bp_cnt, vcnt;
    int  cd[4];

    arb_grant_handshake #(
        .NUM_PORTS (4),
        .CNT_W     (4)
    ) dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .req_arb_o (req_arb),
        .gnt_i     (gnt),
        .addr_o    (addr),
        .valid_o   (valid),
        .ready_i   (ready),
        .ack_o     (ack),
        .busy_o    (busy),
        .evt_cnt_o (evt_cnt),
        .err_o     (err)
    );

    always #5 clk = ~clk;

    // Fixed-priority arbiter; in malformed mode it echoes every request as grant.
    always_comb begin
        gnt = malformed ? req_arb : (req_arb & (~req_arb + 4'd1));
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every FIFO acceptance and checks protocol rules.
    int  m_served, m_exp_cnt, m_prev_addr;
    bit  m_prev_valid, m_prev_acc;
    logic [3:0] m_prev_ack;
    always @(negedge clk) begin
        if (!rst_n) begin
            m_prev_valid = 0; m_prev_acc = 0; m_prev_ack = 0;
            m_exp_cnt = 0; m_served = 0; m_prev_addr = 0;
        end else begin
            if (busy) chk("req_arb_gated", req_arb, 0);
            else      chk("req_arb_pass", req_arb, req);
            if (m_prev_valid && !m_prev_acc) begin
                chk("valid_held", valid, 1);
                chk("addr_stable", addr, m_prev_addr);
            end
            if (valid) chk("ack_low_in_send", ack, 0);
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_accept", 1, 0);
                end else begin
                    m_served = exp_q.pop_front();
                    chk("addr", addr, m_served);
                end
            end
            if (ack != 0) chk("ack_onehot", ack, 1 << m_served);
            if (m_prev_ack != 0 && ack == 0) begin
                m_exp_cnt = (m_exp_cnt + 1) % 16;
                chk("evt_cnt", evt_cnt, m_exp_cnt);
            end
            m_prev_valid = valid;
            m_prev_acc   = valid && ready;
            m_prev_addr  = addr;
            m_prev_ack   = ack;
        end
    end

    // One clock: ports drop their request 0-2 cycles after ack (or early in SEND), FIFO picks ready.
    task automatic step();
        @(posedge clk);
        #2;
        if (valid) vcnt++;
        for (int p = 0; p < 4; p++) begin
            if (!req[p]) begin
                cd[p] = -1;
            end else if (early_mode && valid && addr == p[1:0]) begin
                req[p] = 1'b0;
            end else if (ack[p]) begin
                if (cd[p] < 0) cd[p] = $urandom_range(0, 2);
                if (cd[p] == 0) begin
                    req[p] = 1'b0;
                    cd[p]  = -1;
                end else begin
                    cd[p]--;
                end
            end
        end
        case (ready_mode)
            0: ready = ($urandom_range(0, 3) != 0);
            1: ready = 1'b1;
            2: begin
                if (valid && bp_cnt < 5) begin
                    ready = 1'b0;
                    bp_cnt++;
                end else begin
                    ready = 1'b1;
                end
            end
            default: ready = 1'b0;
        endcase
    endtask

    // A batch: ports in mask request together and each holds until acknowledged,
    // so a fixed-priority arbiter must serve them in ascending index order.
    task automatic run_batch(input logic [3:0] mask, input bit mal, input bit early, input int exp_vcnt);
        int n;
        malformed  = mal;
        early_mode = early;
        bp_cnt     = 0;
        vcnt       = 0;
        for (int p = 0; p < 4; p++) if (mask[p]) exp_q.push_back(p);
        if (mal && $countones(mask) >= 2) err_exp = 1;
        req = mask;
        n = 0;
        do begin
            step();
            n++;
        end while ((req != 0 || busy) && n < 300);
        chk("batch_done", int'(req != 0 || busy), 0);
        if (exp_vcnt >= 0) chk("valid_cycles", vcnt, exp_vcnt);
        chk("err_o", err, err_exp);
        malformed = 0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_addr", addr, 0);
        chk("rst_valid", valid, 0);
        chk("rst_ack", ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt", evt_cnt, 0);
        chk("rst_err", err, 0);
    endtask

    initial begin
        int n;
        logic [3:0] m;
        rst_n = 1'b0; req = '0; ready = 1'b0;
        malformed = 0; early_mode = 0; err_exp = 0;
        ready_mode = 1; bp_cnt = 0; vcnt = 0;
        for (int p = 0; p < 4; p++) cd[p] = -1;

        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        rst_n = 1'b1;

        run_batch(4'b0100, 0, 0, 1);
        chk("single_evt_cnt", evt_cnt, 1);
        run_batch(4'b1010, 0, 0, -1);
        ready_mode = 2;
        run_batch(4'b1000, 0, 0, 6);
        ready_mode = 1;
        run_batch(4'b0010, 0, 1, 1);

        ready_mode = 0;
        for (int i = 0; i < 40; i++) begin
            m = 4'($urandom_range(1, 15));
            run_batch(m, 0, ($urandom_range(0, 3) == 0), -1);
        end

        ready_mode = 1;
        run_batch(4'b0110, 1, 0, -1);
        run_batch(4'b0001, 0, 0, -1);

        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        err_exp = 0;
        exp_q.delete();
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            m = 4'b0001 << $urandom_range(0, 3);
            run_batch(m, 0, 0, -1);
        end
        chk("wrap_16", evt_cnt, 0);
        run_batch(4'b0100, 0, 0, -1);
        chk("wrap_17", evt_cnt, 1);

        // Reset while the FIFO is stalled in SEND: the event is dropped and re-served.
        ready_mode = 3;
        req = 4'b0001;
        exp_q.push_back(0);
        n = 0;
        while (!valid && n < 20) begin
            step();
            n++;
        end
        chk("midsend_valid", valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        step();
        exp_q.delete();
        rst_n = 1'b1;
        ready_mode = 1;
        run_batch(4'b0001, 0, 0, 1);
        chk("midsend_evt", evt_cnt, 1);

        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
